// File: rtl/relu_bwd_seq.sv
// ReLU-derivative backprop sequencer: reads z/g from sync RAMs and streams delta = relu'(z) ? g : 0.
// Latency: first beat valid 3 cycles after the start edge; 1 beat/cycle sustained; credit-limited 2-entry output buffer.
module relu_bwd_seq #(
    parameter int NBITS  = 16,
    parameter int FRAC   = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [NBITS-1:0]  z_data_i,
    input  logic [NBITS-1:0]  g_data_i,
    output logic              d_valid_o,
    input  logic              d_ready_i,
    output logic [NBITS-1:0]  d_data_o,
    output logic [ADDR_W-1:0] d_idx_o,
    output logic              d_last_o
);

    localparam int               LW      = ADDR_W + 1;
    localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
    localparam logic [NBITS-1:0] ONE     = NBITS'(1 << FRAC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] infl_idx_q;
    logic              infl_last_q;

    logic [NBITS-1:0]  buf_dat_q  [2];
    logic [ADDR_W-1:0] buf_idx_q  [2];
    logic              buf_last_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q;

    logic              start_ok, pop, room, rd_last;
    logic [1:0]        occ;
    logic [LW-1:0]     len_clamp;
    logic [NBITS-1:0]  relu_d, cap_dat;
    logic              unused_z;

    // relu'(z) scaled by 2^FRAC is either 0 or exactly ONE, so the product
    // shifted back down by FRAC collapses to a select of g.
    assign relu_d   = z_data_i[NBITS-1] ? '0 : ONE;
    assign cap_dat  = (relu_d == ONE) ? g_data_i : '0;
    assign unused_z = ^z_data_i[NBITS-2:0];

    assign start_ok  = (state_q == S_IDLE) && start_i && !clear_i;
    assign len_clamp = (len_i > DEPTH_L) ? DEPTH_L : len_i;
    assign d_valid_o = (cnt_q != 2'd0);
    assign pop       = d_valid_o && d_ready_i;
    // A beat leaving this cycle returns its credit immediately, which is what
    // lets the pipeline sustain one beat per cycle with only two entries.
    assign occ       = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
    assign room      = (occ < 2'd2);
    assign rd_en_o   = (state_q == S_RUN) && room;
    assign rd_last   = (rd_cnt_q == len_q - LW'(1));
    assign rd_addr_o = rd_en_o ? rd_cnt_q[ADDR_W-1:0] : rd_addr_q;

    assign busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o    = (state_q == S_DONE);
    assign d_data_o  = d_valid_o ? buf_dat_q[rd_ptr_q]  : '0;
    assign d_idx_o   = d_valid_o ? buf_idx_q[rd_ptr_q]  : '0;
    assign d_last_o  = d_valid_o ? buf_last_q[rd_ptr_q] : 1'b0;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    len_d    = len_clamp;
                    rd_cnt_d = '0;
                    state_d  = (len_clamp == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (rd_en_o) begin
                    rd_cnt_d = rd_cnt_q + LW'(1);
                    if (rd_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && buf_last_q[rd_ptr_q]) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            infl_idx_q  <= '0;
            infl_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_cnt_q   <= rd_cnt_d;
            inflight_q <= rd_en_o && !clear_i;
            if (rd_en_o) begin
                rd_addr_q   <= rd_cnt_q[ADDR_W-1:0];
                infl_idx_q  <= rd_cnt_q[ADDR_W-1:0];
                infl_last_q <= rd_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_dat_q[i]  <= '0;
                buf_idx_q[i]  <= '0;
                buf_last_q[i] <= 1'b0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (inflight_q) begin
                buf_dat_q[wr_ptr_q]  <= cap_dat;
                buf_idx_q[wr_ptr_q]  <= infl_idx_q;
                buf_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_relu_bwd_seq.sv
// Directed bench for relu_bwd_seq with a queue-based reference of the expected delta stream.
module tb_relu_bwd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [4:0]  len_i = '0;
    logic        busy_o, done_o, rd_en_o, d_valid_o, d_last_o;
    logic [3:0]  rd_addr_o, d_idx_o;
    logic [15:0] z_data = '0, g_data = '0, d_data_o;
    logic        d_ready_i = 1'b0;

    relu_bwd_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .z_data_i(z_data), .g_data_i(g_data), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
        .d_data_o(d_data_o), .d_idx_o(d_idx_o), .d_last_o(d_last_o)
    );

    always #5 clk = ~clk;

    logic [15:0] z_mem [16];
    logic [15:0] g_mem [16];

    always @(posedge clk) if (rd_en_o) begin
        z_data <= z_mem[rd_addr_o];
        g_data <= g_mem[rd_addr_o];
    end

    typedef struct {logic [15:0] dat; logic [3:0] idx; logic last;} beat_t;
    beat_t expq[$];

    int vecs = 0, errs = 0;
    int cyc = 0, t0 = 0, first_rel = 0, done_rel = 0, last_rel = 0;
    int done_cnt = 0, done_base = 0, beats = 0, issued = 0, accepted = 0, exp_rd = 0;
    logic [15:0] obs_dat [16];
    logic [3:0]  obs_idx [16];
    logic        prev_stall = 1'b0, prev_clear = 1'b0, prev_last = 1'b0;
    logic [15:0] prev_dat = '0;
    logic [3:0]  prev_idx = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: delta = (g * relu'(z)) >>> 8 with relu' = 256 for z >= 0.
    task automatic build_model(input int l);
        int n;
        n = (l > 16) ? 16 : l;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            int prod;
            prod  = int'($signed(g_mem[i])) * (($signed(z_mem[i]) >= 0) ? 256 : 0);
            b.dat = 16'(prod >>> 8);
            b.idx = 4'(i);
            b.last = (i == n - 1);
            expq.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        logic pop_now;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            pop_now = d_valid_o && d_ready_i;
            if (done_o) begin done_cnt++; done_rel = cyc - t0; end
            if (prev_stall && !prev_clear) begin
                chk("stall_valid", d_valid_o, 1'b1);
                chk("stall_data", {d_data_o, d_idx_o, d_last_o}, {prev_dat, prev_idx, prev_last});
            end
            if (rd_en_o) begin
                chk("credit", ((issued - accepted - int'(pop_now)) < 2), 1'b1);
                chk("rd_addr", rd_addr_o, exp_rd);
                exp_rd++;
                issued++;
            end
            if (d_valid_o) begin
                if (first_rel == 0) first_rel = cyc - t0;
                if (expq.size() == 0) begin
                    chk("spurious_beat", d_valid_o, 1'b0);
                end else begin
                    chk("d_data", d_data_o, expq[0].dat);
                    chk("d_idx", d_idx_o, expq[0].idx);
                    chk("d_last", d_last_o, expq[0].last);
                    if (d_ready_i) begin
                        if (beats < 16) begin obs_dat[beats] = d_data_o; obs_idx[beats] = d_idx_o; end
                        void'(expq.pop_front());
                        accepted++;
                        beats++;
                        last_rel = cyc - t0;
                    end
                end
            end
            prev_stall = d_valid_o && !d_ready_i;
            prev_clear = clear_i;
            prev_dat = d_data_o; prev_idx = d_idx_o; prev_last = d_last_o;
        end
    end

    task automatic do_start(input int l, input bit model);
        @(posedge clk); #1;
        start_i = 1'b1; len_i = 5'(l);
        @(posedge clk); #1;
        start_i = 1'b0;
        if (model) begin
            build_model(l);
            t0 = cyc; first_rel = 0; beats = 0; exp_rd = 0; done_base = done_cnt;
        end
    endtask

    task automatic wait_done(input int bound);
        for (int k = 0; k < bound && done_cnt == done_base; k++) begin
            @(negedge clk); #1;
        end
        chk("done_seen", done_cnt != done_base, 1'b1);
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 200 && beats < n; k++) begin
            @(posedge clk); #1;
        end
        chk("beats_reached", beats >= n, 1'b1);
    endtask

    task automatic flush_model();
        expq.delete();
        issued = 0; accepted = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int d0, i0;
        for (int i = 0; i < 16; i++) begin
            z_mem[i] = ((i % 3) == 0) ? (16'h8000 | 16'(i)) : 16'(i * 16'h0111);
            g_mem[i] = 16'h1000 + 16'(i * 16'h0123);
        end

        // reset state
        #2;
        chk("reset_outputs", {busy_o, done_o, rd_en_o, rd_addr_o, d_valid_o, d_data_o, d_idx_o, d_last_o}, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: len=4, mixed signs, d_ready high
        z_mem[0] = 16'h0100; z_mem[1] = 16'hFF00; z_mem[2] = 16'h0000; z_mem[3] = 16'h8001;
        g_mem[0] = 16'h0280; g_mem[1] = 16'h0300; g_mem[2] = 16'hFE00; g_mem[3] = 16'h0050;
        d_ready_i = 1'b1;
        do_start(4, 1'b1);
        chk("model_b0", expq[0].dat, 16'h0280);
        chk("model_b1", expq[1].dat, 16'h0000);
        chk("model_b2", expq[2].dat, 16'hFE00);
        chk("model_b3", {expq[3].dat, 3'b0, expq[3].last}, {16'h0000, 4'h1});
        chk("t1_busy", busy_o, 1'b1);
        wait_done(40);
        chk("t1_first_valid", first_rel, 3);
        chk("t1_beats", beats, 4);
        chk("t1_done_after_last", done_rel, last_rel + 1);
        chk("t1_done_time", done_rel, 7);
        chk("t1_obs", {obs_dat[0], obs_dat[1], obs_dat[2], obs_dat[3]}, 64'h0280_0000_FE00_0000);
        chk("t1_obs_idx3", obs_idx[3], 4'd3);
        @(negedge clk);
        chk("t1_done_pulse", done_o, 1'b0);

        // 2: len=16 with 1010 ready pattern then a 5-cycle stall
        for (int i = 0; i < 16; i++) begin
            z_mem[i] = ((i % 3) == 0) ? (16'h8000 | 16'(i)) : 16'(i * 16'h0111);
            g_mem[i] = 16'h1000 + 16'(i * 16'h0123);
        end
        do_start(16, 1'b1);
        for (int k = 0; k < 300 && done_cnt == done_base; k++) begin
            @(posedge clk); #1;
            d_ready_i = (k < 10) ? ((k % 2) == 0) : ((k < 15) ? 1'b0 : 1'b1);
        end
        chk("t2_done", done_cnt, done_base + 1);
        chk("t2_beats", beats, 16);
        chk("t2_queue_empty", expq.size(), 0);
        chk("t2_obs_mask", {obs_dat[0], obs_dat[1]}, {16'h0000, 16'h1123});
        d_ready_i = 1'b1;

        // 3: len=0, start+clear together, len=20 clamp
        do_start(0, 1'b1);
        @(negedge clk); #1;
        chk("t3_len0_done", {done_o, busy_o}, 2'b10);
        chk("t3_len0_done_time", done_rel, 1);
        i0 = issued;
        repeat (4) @(negedge clk);
        #1;
        chk("t3_len0_no_rd", issued, i0);
        chk("t3_len0_no_beats", beats, 0);
        d0 = done_cnt;
        @(posedge clk); #1;
        start_i = 1'b1; clear_i = 1'b1; len_i = 5'd4;
        @(posedge clk); #1;
        start_i = 1'b0; clear_i = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("t3_clear_wins", {busy_o, rd_en_o, d_valid_o}, 3'b000);
        chk("t3_clear_no_done", done_cnt, d0);
        chk("t3_clear_no_rd", issued, i0);
        do_start(20, 1'b1);
        wait_done(100);
        chk("t3_clamp_beats", beats, 16);

        // 4: second start during beat 2 of len=8
        do_start(8, 1'b1);
        wait_beats(2);
        start_i = 1'b1; len_i = 5'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(100);
        repeat (5) @(negedge clk);
        #1;
        chk("t4_beats", beats, 8);
        chk("t4_single_done", done_cnt, done_base + 1);
        chk("t4_idle", busy_o, 1'b0);

        // 5: clear at beat 3 of len=8 while stalled, then restart
        do_start(8, 1'b1);
        wait_beats(3);
        d_ready_i = 1'b0;
        @(posedge clk); #1;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        flush_model();
        @(negedge clk);
        chk("t5_valid_dropped", {d_valid_o, busy_o}, 2'b00);
        repeat (4) @(negedge clk);
        chk("t5_no_done", done_cnt, done_base);
        chk("t5_no_valid", d_valid_o, 1'b0);
        #1 d_ready_i = 1'b1;
        do_start(8, 1'b1);
        wait_done(100);
        chk("t5_restart_idx0", obs_idx[0], 4'd0);
        chk("t5_restart_beats", beats, 8);

        // 6: async reset mid-pass, then clean pass
        do_start(16, 1'b1);
        wait_beats(5);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", {busy_o, done_o, rd_en_o, rd_addr_o, d_valid_o, d_data_o, d_idx_o, d_last_o}, '0);
        flush_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_start(5, 1'b1);
        wait_done(60);
        chk("t6_beats", beats, 5);
        chk("t6_first_valid", first_rel, 3);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
